// File: rtl/spi_pkg.sv
// Shared definitions for the read-only SPI master.
// Holds the FSM state encoding and the default parameter values that the
// interface, the half-period counter and the master itself all build on.
package spi_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_HALF_DIV   = 4;
    localparam int DEF_LD_CYCLES  = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        DONE     = 3'd4
    } spi_state_t;

endpackage

// File: rtl/spimaster_rd_if.sv
// Bus bundle between the SPI read master and its user / shift-register slave.
//   start, abort : transfer request and synchronous cancel (into the master)
//   sdi          : serial data from the slave, MSB first (into the master)
//   busy         : master is not idle
//   sck, ld, ss_n: serial clock, parallel-load strobe, slave select (active low)
//   data_o, valid: last received word and its one-cycle strobe
// Modport master is taken by spimaster_rd, modport slave by the surroundings.
import spi_pkg::*;

interface spimaster_rd_if #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  start;
    logic                  abort;
    logic                  sdi;
    logic                  busy;
    logic                  sck;
    logic                  ld;
    logic                  ss_n;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid;

    modport master (
        input  start, abort, sdi,
        output busy, sck, ld, ss_n, data_o, valid
    );

    modport slave (
        output start, abort, sdi,
        input  busy, sck, ld, ss_n, data_o, valid
    );
endinterface

// File: rtl/spimaster_baud.sv
// Half-period counter for the SPI read master.
//   clk, rst_n : system clock, asynchronous active-low reset
//   clr        : restart the count (asserted on every FSM state change)
//   en         : count enable (high only while shifting)
//   tc         : one-cycle pulse on the HALF_DIV-th enabled cycle
import spi_pkg::*;

module spimaster_baud #(
    parameter int HALF_DIV = DEF_HALF_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    logic [CW-1:0] cnt_reg;

    assign tc = en && (cnt_reg == CW'(HALF_DIV - 1));

    // Wrap on tc so the count never runs past one half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr || !en || tc) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end
endmodule

// File: rtl/spimaster_rd.sv
// SPI read master: strobes ld to a parallel-in/serial-out slave, clocks
// DATA_WIDTH bits in MSB first (sampled at the end of each sck-high phase),
// and presents the word on data_o with a one-cycle valid pulse.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : spimaster_rd_if master modport (start/abort/sdi in,
//                busy/sck/ld/ss_n/data_o/valid out)
// Every output is a flop loaded from the next-state decode, so outputs line
// up with the state register and no input reaches an output combinationally.
import spi_pkg::*;

module spimaster_rd #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int HALF_DIV   = DEF_HALF_DIV,
    parameter int LD_CYCLES  = DEF_LD_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spimaster_rd_if.master        bus
);
    localparam int LCW = $clog2(LD_CYCLES + 1);
    localparam int BCW = $clog2(DATA_WIDTH + 1);

    spi_state_t            state_reg, state_next;
    logic [LCW-1:0]        ld_cnt_reg;
    logic [BCW-1:0]        bit_cnt_reg;
    logic [DATA_WIDTH-1:0] rx_reg;
    logic [DATA_WIDTH-1:0] data_o_reg;
    logic                  busy_reg, sck_reg, ld_reg, ss_n_reg, valid_reg;
    logic                  baud_clr, baud_en, baud_tc;

    spimaster_baud #(.HALF_DIV(HALF_DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (baud_clr),
        .en    (baud_en),
        .tc    (baud_tc)
    );

    assign baud_en  = (state_reg == SHIFT_HI) || (state_reg == SHIFT_LO);
    assign baud_clr = (state_next != state_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (bus.start) state_next = LOAD;
            LOAD:     if (ld_cnt_reg == LCW'(LD_CYCLES - 1)) state_next = SHIFT_HI;
            SHIFT_HI: if (baud_tc) state_next = SHIFT_LO;
            SHIFT_LO: if (baud_tc) begin
                          state_next = (bit_cnt_reg == BCW'(DATA_WIDTH - 1)) ? DONE : SHIFT_HI;
                      end
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        // Abort outranks every transition, including the step into DONE.
        if (bus.abort && (state_reg != IDLE)) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // LOAD length counter: zero on entry, counts while LOAD persists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_reg <= '0;
        end else if ((state_reg == LOAD) && (state_next == LOAD)) begin
            ld_cnt_reg <= ld_cnt_reg + LCW'(1);
        end else begin
            ld_cnt_reg <= '0;
        end
    end

    // Bit counter counts completed HI/LO pairs; it survives the HI<->LO hops
    // of one word and is cleared whenever the shift sequence is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg <= '0;
        end else if ((state_reg == SHIFT_LO) && (state_next == SHIFT_HI)) begin
            bit_cnt_reg <= bit_cnt_reg + BCW'(1);
        end else if ((state_next != SHIFT_HI) && (state_next != SHIFT_LO)) begin
            bit_cnt_reg <= '0;
        end
    end

    // Receive register: sample sdi on the last cycle of each sck-high phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_reg <= '0;
        end else if ((state_reg == IDLE) && (state_next == LOAD)) begin
            rx_reg <= '0;
        end else if ((state_reg == SHIFT_HI) && baud_tc) begin
            rx_reg <= {rx_reg[DATA_WIDTH-2:0], bus.sdi};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg   <= 1'b0;
            sck_reg    <= 1'b0;
            ld_reg     <= 1'b0;
            ss_n_reg   <= 1'b1;
            valid_reg  <= 1'b0;
            data_o_reg <= '0;
        end else begin
            busy_reg  <= (state_next != IDLE);
            sck_reg   <= (state_next == SHIFT_HI);
            ld_reg    <= (state_next == LOAD);
            ss_n_reg  <= !((state_next == LOAD) || (state_next == SHIFT_HI) ||
                           (state_next == SHIFT_LO));
            valid_reg <= (state_next == DONE);
            if (state_next == DONE) begin
                data_o_reg <= rx_reg;
            end
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.sck    = sck_reg;
    assign bus.ld     = ld_reg;
    assign bus.ss_n   = ss_n_reg;
    assign bus.valid  = valid_reg;
    assign bus.data_o = data_o_reg;
endmodule

// File: tb/tb_spimaster_rd.sv
// Bench for spimaster_rd: two instances (defaults, and 12-bit/HALF_DIV=2),
// each driven by a behavioural parallel-load shift-register slave.
module tb_spimaster_rd;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spimaster_rd_if #(.DATA_WIDTH(8))  bus8 ();
    spimaster_rd_if #(.DATA_WIDTH(12)) bus12 ();

    spimaster_rd dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    spimaster_rd #(.DATA_WIDTH(12), .HALF_DIV(2), .LD_CYCLES(2)) dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus12)
    );

    int compared   = 0;
    int mismatched = 0;

    // Expected latency from the start-sampling cycle to the valid pulse.
    function automatic int exp_lat(input int w, input int h, input int l);
        return l + 2 * h * w + 1;
    endfunction

    // Slave models: load on ld, present MSB on sdi, advance on sck falling.
    logic [7:0]  slave_word8,  sh8;
    logic [11:0] slave_word12, sh12;
    logic        prev_sck8, prev_sck12;

    always @(posedge clk) begin
        prev_sck8 <= bus8.sck;
        if (bus8.ld) sh8 <= slave_word8;
        else if (prev_sck8 && !bus8.sck) sh8 <= {sh8[6:0], 1'b0};
        prev_sck12 <= bus12.sck;
        if (bus12.ld) sh12 <= slave_word12;
        else if (prev_sck12 && !bus12.sck) sh12 <= {sh12[10:0], 1'b0};
    end
    assign bus8.sdi  = sh8[7];
    assign bus12.sdi = sh12[11];

    // One 8-bit transfer observed for 200 cycles. Cycle n is the state seen
    // after the n-th edge; edge 1 samples start. abort is high during cycle
    // abort_at (0 = never); ss_n/busy are captured in cycle abort_at+1.
    task automatic xfer8(input logic [7:0] w, input int hold, input int abort_at,
                         output int vcyc, output int nval, output int nld,
                         output int nsck, output logic [7:0] dseen,
                         output logic ss_ab, output logic busy_ab);
        logic psck;
        slave_word8 = w;
        vcyc = -1; nval = 0; nld = 0; nsck = 0; dseen = 8'h00;
        ss_ab = 1'b0; busy_ab = 1'b1;
        psck = bus8.sck;
        bus8.start = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n >= hold) bus8.start = 1'b0;
            bus8.abort = (n == abort_at);
            if (bus8.valid) begin
                nval++;
                if (vcyc < 0) begin vcyc = n; dseen = bus8.data_o; end
            end
            if (bus8.ld) nld++;
            if (bus8.sck && !psck) nsck++;
            psck = bus8.sck;
            if (n == abort_at + 1) begin ss_ab = bus8.ss_n; busy_ab = bus8.busy; end
        end
        bus8.abort = 1'b0;
        $display("xfer8 word=%h hold=%0d abort_at=%0d valid_cycle=%0d valids=%0d data=%h ld=%0d sck=%0d",
                 w, hold, abort_at, vcyc, nval, dseen, nld, nsck);
    endtask

    task automatic xfer12(input logic [11:0] w, output int vcyc, output int nval,
                          output logic [11:0] dseen);
        slave_word12 = w;
        vcyc = -1; nval = 0; dseen = 12'h000;
        bus12.start = 1'b1;
        for (int n = 1; n <= 120; n++) begin
            @(posedge clk); #1;
            bus12.start = 1'b0;
            if (bus12.valid) begin
                nval++;
                if (vcyc < 0) begin vcyc = n; dseen = bus12.data_o; end
            end
        end
        $display("xfer12 word=%h valid_cycle=%0d valids=%0d data=%h", w, vcyc, nval, dseen);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.abort = 1'b0;
        bus12.start = 1'b0; bus12.abort = 1'b0;
        slave_word8 = 8'h00; slave_word12 = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if ({bus8.busy, bus8.sck, bus8.ld, bus8.ss_n, bus8.valid} !== 5'b00010) begin
            mismatched++;
            $display("FAIL reset_ctrl: got busy/sck/ld/ss_n/valid=%b required 00010",
                     {bus8.busy, bus8.sck, bus8.ld, bus8.ss_n, bus8.valid});
        end
        compared++;
        if (bus8.data_o !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_data: got %h required 00", bus8.data_o);
        end
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic();
        int vc, nv, nl, ns; logic [7:0] d; logic sa, ba;
        xfer8(8'hA5, 1, 0, vc, nv, nl, ns, d, sa, ba);
        compared++;
        if (vc !== exp_lat(8, 4, 2)) begin
            mismatched++; $display("FAIL basic_latency: got %0d required %0d", vc, exp_lat(8, 4, 2));
        end
        compared++;
        if (d !== 8'hA5) begin mismatched++; $display("FAIL basic_data: got %h required a5", d); end
        compared++;
        if (nl !== 2) begin mismatched++; $display("FAIL basic_ld_cycles: got %0d required 2", nl); end
        compared++;
        if (ns !== 8) begin mismatched++; $display("FAIL basic_sck_pulses: got %0d required 8", ns); end
        compared++;
        if (nv !== 1) begin mismatched++; $display("FAIL basic_valid_count: got %0d required 1", nv); end
    endtask

    task automatic test_back_to_back();
        int vcyc[2]; logic [7:0] vdat[2]; int k;
        k = 0;
        slave_word8 = 8'h3C;
        bus8.start = 1'b1;
        for (int n = 1; n <= 250; n++) begin
            @(posedge clk); #1;
            if (n == 1) bus8.start = 1'b0;
            if (bus8.valid && k < 2) begin
                vcyc[k] = n; vdat[k] = bus8.data_o; k++;
                if (k == 1) slave_word8 = 8'hFF;
            end
            // First IDLE cycle after DONE carries the next request.
            if (k == 1 && n == vcyc[0] + 1) bus8.start = 1'b1;
            if (k == 1 && n == vcyc[0] + 2) bus8.start = 1'b0;
        end
        $display("back_to_back valids=%0d", k);
        compared++;
        if (k !== 2) begin
            mismatched++; $display("FAIL b2b_count: got %0d required 2", k);
        end else begin
            compared++;
            if (vcyc[1] - vcyc[0] !== 68) begin
                mismatched++; $display("FAIL b2b_spacing: got %0d required 68", vcyc[1] - vcyc[0]);
            end
            compared++;
            if (vdat[0] !== 8'h3C) begin mismatched++; $display("FAIL b2b_data0: got %h required 3c", vdat[0]); end
            compared++;
            if (vdat[1] !== 8'hFF) begin mismatched++; $display("FAIL b2b_data1: got %h required ff", vdat[1]); end
        end
    endtask

    task automatic test_start_held();
        int vc, nv, nl, ns; logic [7:0] d; logic sa, ba;
        xfer8(8'h6E, 10, 0, vc, nv, nl, ns, d, sa, ba);
        compared++;
        if (nv !== 1) begin mismatched++; $display("FAIL held_valid_count: got %0d required 1", nv); end
        compared++;
        if (d !== 8'h6E) begin mismatched++; $display("FAIL held_data: got %h required 6e", d); end
    endtask

    task automatic test_abort();
        int vc, nv, nl, ns; logic [7:0] d; logic sa, ba;
        xfer8(8'h11, 1, 0, vc, nv, nl, ns, d, sa, ba);
        compared++;
        if (d !== 8'h11) begin mismatched++; $display("FAIL abort_pre_data: got %h required 11", d); end
        xfer8(8'h5A, 1, 30, vc, nv, nl, ns, d, sa, ba);
        compared++;
        if (nv !== 0) begin mismatched++; $display("FAIL abort_no_valid: got %0d required 0", nv); end
        compared++;
        if ({sa, ba} !== 2'b10) begin
            mismatched++; $display("FAIL abort_ssn_busy: got ss_n/busy=%b required 10", {sa, ba});
        end
        compared++;
        if (bus8.data_o !== 8'h11) begin mismatched++; $display("FAIL abort_data_hold: got %h required 11", bus8.data_o); end
        // Abort in the last SHIFT_LO cycle, just as DONE would be entered.
        xfer8(8'hC3, 1, exp_lat(8, 4, 2) - 1, vc, nv, nl, ns, d, sa, ba);
        compared++;
        if (nv !== 0) begin mismatched++; $display("FAIL abort_done_no_valid: got %0d required 0", nv); end
        compared++;
        if (bus8.data_o !== 8'h11) begin mismatched++; $display("FAIL abort_done_data_hold: got %h required 11", bus8.data_o); end
    endtask

    task automatic test_random();
        int vc, nv, nl, ns; logic [7:0] d, w; logic sa, ba;
        for (int i = 0; i < 4; i++) begin
            w = 8'($urandom_range(0, 255));
            xfer8(w, 1, 0, vc, nv, nl, ns, d, sa, ba);
            compared++;
            if (d !== w || vc !== exp_lat(8, 4, 2)) begin
                mismatched++;
                $display("FAIL random_xfer%0d: got data=%h cycle=%0d required data=%h cycle=%0d",
                         i, d, vc, w, exp_lat(8, 4, 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        int vc, nv, nl, ns, nval; logic [7:0] d; logic sa, ba;
        nval = 0;
        slave_word8 = 8'h77;
        bus8.start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            bus8.start = 1'b0;
            if (bus8.valid) nval++;
            if (n == 20) begin
                rst_n = 1'b0;
                #1;
                compared++;
                if ({bus8.busy, bus8.sck, bus8.ld, bus8.ss_n, bus8.valid} !== 5'b00010 ||
                    bus8.data_o !== 8'h00) begin
                    mismatched++;
                    $display("FAIL reset_async: got ctrl=%b data=%h required ctrl=00010 data=00",
                             {bus8.busy, bus8.sck, bus8.ld, bus8.ss_n, bus8.valid}, bus8.data_o);
                end
            end
            if (n == 23) rst_n = 1'b1;
        end
        $display("reset_mid valids=%0d", nval);
        compared++;
        if (nval !== 0) begin mismatched++; $display("FAIL reset_no_valid: got %0d required 0", nval); end
        xfer8(8'h81, 1, 0, vc, nv, nl, ns, d, sa, ba);
        compared++;
        if (d !== 8'h81 || vc !== exp_lat(8, 4, 2)) begin
            mismatched++;
            $display("FAIL reset_after_xfer: got data=%h cycle=%0d required data=81 cycle=%0d",
                     d, vc, exp_lat(8, 4, 2));
        end
    endtask

    task automatic test_width12();
        int vc, nv; logic [11:0] d, w;
        xfer12(12'hF0A, vc, nv, d);
        compared++;
        if (vc !== exp_lat(12, 2, 2)) begin
            mismatched++; $display("FAIL w12_latency: got %0d required %0d", vc, exp_lat(12, 2, 2));
        end
        compared++;
        if (d !== 12'hF0A || nv !== 1) begin
            mismatched++; $display("FAIL w12_data: got %h (valids %0d) required f0a (valids 1)", d, nv);
        end
        for (int i = 0; i < 2; i++) begin
            w = 12'($urandom_range(0, 4095));
            xfer12(w, vc, nv, d);
            compared++;
            if (d !== w) begin mismatched++; $display("FAIL w12_random%0d: got %h required %h", i, d, w); end
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_basic();
        test_back_to_back();
        test_start_held();
        test_abort();
        test_random();
        test_reset_mid();
        test_width12();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
